kb_char_sequencer: RTL

Sequences the PS/2 keyboard decode path and turns raw scan-code bytes into a stream of typed characters for the notepad text buffer. It parses set-2 make/break/extended prefixes and tracks Shift and Caps Lock. It drives the scan-to-ASCII translator, filters out codes the translator does not know, and applies case. It also buffers the resulting characters in a small FIFO behind a valid/ready handshake.

---
 rtl/kb_char_sequencer_if.sv | 24 ++
 rtl/kb_char_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/kb_char_sequencer_if.sv
// Scan-byte, translator and character-stream signals between the keyboard
// sequencer (slave) and its environment (master).
interface kb_char_sequencer_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [7:0] key_code;
    logic [6:0] ascii_in;
    logic [6:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic       overflow;
    logic       shift_active;
    logic       caps_active;

    modport slave (
        input  scan_code, scan_valid, ascii_in, char_ready,
        output key_code, char_out, char_valid, overflow, shift_active, caps_active
    );

    modport master (
        output scan_code, scan_valid, ascii_in, char_ready,
        input  key_code, char_out, char_valid, overflow, shift_active, caps_active
    );
endinterface

// File: rtl/kb_char_sequencer.sv
// PS/2 set-2 scan-code parser with Shift/Caps tracking, translator filtering and
// case folding, feeding a small character FIFO with a valid/ready output.
module kb_char_sequencer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                resetn,
    kb_char_sequencer_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t          r_state, w_state_next;
    logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt_next;
    logic            r_lshift, r_rshift, r_caps;
    logic            w_lshift_next, w_rshift_next, w_caps_next;
    logic            w_push, w_is_letter, w_tmo_hit;
    logic [6:0]      w_push_data;

    logic [6:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr, r_wr_ptr, w_rd_ptr_next, w_wr_ptr_next;
    logic [CW-1:0]   r_count, w_count_next;
    logic            r_char_valid, r_overflow;
    logic [6:0]      r_char_out, w_char_out_next;
    logic            w_pop, w_full, w_do_write, w_overflow_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Prefix parsing, modifier tracking and character selection
    always_comb begin
        w_state_next   = r_state;
        w_tmo_cnt_next = r_tmo_cnt;
        w_lshift_next  = r_lshift;
        w_rshift_next  = r_rshift;
        w_caps_next    = r_caps;
        w_push         = 1'b0;
        w_push_data    = 7'd0;
        w_tmo_hit      = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        w_is_letter    = (bus.ascii_in >= 7'd65) && (bus.ascii_in <= 7'd90);
        if (bus.scan_valid) begin
            w_tmo_cnt_next = '0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.scan_code == 8'hF0)      w_state_next = S_BRK;
                    else if (bus.scan_code == 8'hE0) w_state_next = S_EXT;
                    else begin
                        unique case (bus.scan_code)
                            8'h12: w_lshift_next = 1'b1;
                            8'h59: w_rshift_next = 1'b1;
                            8'h58: w_caps_next   = ~r_caps;
                            8'h66: begin w_push = 1'b1; w_push_data = 7'd8;  end
                            8'h5A: begin w_push = 1'b1; w_push_data = 7'd13; end
                            default: begin
                                w_push = (bus.ascii_in != 7'd32) || (bus.scan_code == 8'h29);
                                if (w_is_letter && !((r_lshift | r_rshift) ^ r_caps))
                                    w_push_data = 7'(bus.ascii_in + 7'd32);
                                else
                                    w_push_data = bus.ascii_in;
                            end
                        endcase
                    end
                end
                S_BRK: begin
                    if (bus.scan_code == 8'h12) w_lshift_next = 1'b0;
                    if (bus.scan_code == 8'h59) w_rshift_next = 1'b0;
                    w_state_next = S_IDLE;
                end
                S_EXT:     w_state_next = (bus.scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: w_state_next = S_IDLE;
                default:   w_state_next = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (w_tmo_hit) begin
                w_state_next   = S_IDLE;
                w_tmo_cnt_next = '0;
            end else begin
                w_tmo_cnt_next = TW'(r_tmo_cnt + TW'(1));
            end
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves this cycle
    always_comb begin
        w_pop           = r_char_valid && bus.char_ready;
        w_full          = (r_count == CW'(DEPTH));
        w_do_write      = w_push && (!w_full || w_pop);
        w_overflow_next = w_push && w_full && !w_pop;
        w_wr_ptr_next   = w_do_write ? AW'(r_wr_ptr + AW'(1)) : r_wr_ptr;
        w_rd_ptr_next   = w_pop ? AW'(r_rd_ptr + AW'(1)) : r_rd_ptr;
        w_count_next    = r_count;
        if (w_do_write && !w_pop)      w_count_next = CW'(r_count + CW'(1));
        else if (!w_do_write && w_pop) w_count_next = CW'(r_count - CW'(1));
        if (w_do_write && (w_rd_ptr_next == r_wr_ptr))
            w_char_out_next = w_push_data;
        else
            w_char_out_next = r_mem[w_rd_ptr_next];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt    <= '0;
            r_lshift     <= 1'b0;
            r_rshift     <= 1'b0;
            r_caps       <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_char_valid <= 1'b0;
            r_char_out   <= 7'd0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= 7'd0;
        end else begin
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_lshift     <= w_lshift_next;
            r_rshift     <= w_rshift_next;
            r_caps       <= w_caps_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_count      <= w_count_next;
            r_char_valid <= (w_count_next != '0);
            r_char_out   <= w_char_out_next;
            r_overflow   <= w_overflow_next;
            if (w_do_write) r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign bus.key_code     = bus.scan_code;
    assign bus.char_out     = r_char_out;
    assign bus.char_valid   = r_char_valid;
    assign bus.overflow     = r_overflow;
    assign bus.shift_active = r_lshift | r_rshift;
    assign bus.caps_active  = r_caps;
endmodule
